// File: rtl/conv_win_addr_gen.sv
// Layer-sweep address sequencer: walks oc, oy, ox, g, ky, kx and emits one input-buffer
// and weight address per kernel tap, tagged with neuron-end and plane-end strobes.
module conv_win_addr_gen #(
    parameter int unsigned IN_W   = 32,
    parameter int unsigned IN_H   = 32,
    parameter int unsigned K      = 5,
    parameter int unsigned OUT_W  = IN_W - K + 1,
    parameter int unsigned OUT_H  = IN_H - K + 1,
    parameter int unsigned CH_GRP = 1,
    parameter int unsigned OUT_CH = 8,
    parameter int unsigned ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_ready,
    output logic              in_valid,
    output logic [ADDR_W-1:0] in_addr,
    output logic [ADDR_W-1:0] wgt_addr,
    output logic [7:0]        oc_idx,
    output logic              first_tap,
    output logic              last_tap,
    output logic              last_pix,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] KLast     = ADDR_W'(K - 1);
    localparam logic [ADDR_W-1:0] GLast     = ADDR_W'(CH_GRP - 1);
    localparam logic [ADDR_W-1:0] OxLast    = ADDR_W'(OUT_W - 1);
    localparam logic [ADDR_W-1:0] OyLast    = ADDR_W'(OUT_H - 1);
    localparam logic [7:0]        OcLast    = 8'(OUT_CH - 1);
    localparam logic [ADDR_W-1:0] RowStep   = ADDR_W'(IN_W);
    localparam logic [ADDR_W-1:0] PlaneStep = ADDR_W'(IN_H * IN_W);
    localparam logic [ADDR_W-1:0] NeuronLen = ADDR_W'(CH_GRP * K * K);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;
    state_e state_q, state_d;

    logic [ADDR_W-1:0] kx_q, ky_q, g_q, ox_q, oy_q;
    logic [7:0]        oc_q;
    // Running partial products replace every multiply in the address equations.
    logic [ADDR_W-1:0] krow_q, nrow_q, plane_q, tap_q, wbase_q;

    logic xfer, kx_end, ky_end, g_end, ox_end, oy_end, oc_end;
    logic tap_end, row_end, pln_end, sweep_end;

    assign xfer      = (state_q == StRun) && in_ready;
    assign kx_end    = (kx_q == KLast);
    assign ky_end    = (ky_q == KLast);
    assign g_end     = (g_q == GLast);
    assign ox_end    = (ox_q == OxLast);
    assign oy_end    = (oy_q == OyLast);
    assign oc_end    = (oc_q == OcLast);
    assign tap_end   = kx_end && ky_end && g_end;
    assign row_end   = tap_end && ox_end;
    assign pln_end   = row_end && oy_end;
    assign sweep_end = pln_end && oc_end;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StRun;
            StRun:   if (xfer && sweep_end) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        in_valid  = (state_q == StRun);
        busy      = (state_q == StRun);
        done      = (state_q == StDone);
        first_tap = in_valid && (g_q == '0) && (ky_q == '0) && (kx_q == '0);
        last_tap  = in_valid && tap_end;
        last_pix  = in_valid && tap_end && ox_end && oy_end;
        in_addr   = plane_q + nrow_q + krow_q + ox_q + kx_q;
        wgt_addr  = wbase_q + tap_q;
        oc_idx    = oc_q;
    end

    // Counters sit at zero outside RUN, so a sweep always begins at tap (0,0,0,0,0,0).
    always_ff @(posedge clk) begin
        if (!rst_n || state_q != StRun) begin
            kx_q    <= '0;
            ky_q    <= '0;
            g_q     <= '0;
            ox_q    <= '0;
            oy_q    <= '0;
            oc_q    <= '0;
            krow_q  <= '0;
            nrow_q  <= '0;
            plane_q <= '0;
            tap_q   <= '0;
            wbase_q <= '0;
        end else if (xfer) begin
            kx_q  <= kx_end ? '0 : kx_q + 1'b1;
            tap_q <= tap_end ? '0 : tap_q + 1'b1;
            if (kx_end) begin
                ky_q   <= ky_end ? '0 : ky_q + 1'b1;
                krow_q <= ky_end ? '0 : krow_q + RowStep;
            end
            if (kx_end && ky_end) begin
                g_q     <= g_end ? '0 : g_q + 1'b1;
                plane_q <= g_end ? '0 : plane_q + PlaneStep;
            end
            if (tap_end) begin
                ox_q <= ox_end ? '0 : ox_q + 1'b1;
            end
            if (row_end) begin
                oy_q   <= oy_end ? '0 : oy_q + 1'b1;
                nrow_q <= oy_end ? '0 : nrow_q + RowStep;
            end
            if (pln_end) begin
                oc_q    <= oc_end ? '0 : oc_q + 1'b1;
                wbase_q <= oc_end ? '0 : wbase_q + NeuronLen;
            end
        end
    end

endmodule

// File: tb/tb_conv_win_addr_gen.sv
// Bench for conv_win_addr_gen: two configurations driven with random stalls and start
// pulses, checked every cycle against a tap-index model that derives all indices by div/mod.
module tb_conv_win_addr_gen;

    logic        clk = 1'b0;
    logic        rst_n [2];
    logic        start [2];
    logic        rdy   [2];
    logic        valid [2];
    logic [15:0] addr  [2];
    logic [15:0] wgt   [2];
    logic [7:0]  oc    [2];
    logic        ft    [2];
    logic        lt    [2];
    logic        lp    [2];
    logic        busy  [2];
    logic        done  [2];

    always #5 clk = ~clk;

    // Instance 0: default geometry, one output channel. Instance 1: small multi-group case.
    int c_iw [2] = '{32, 6};
    int c_ih [2] = '{32, 6};
    int c_k  [2] = '{5, 3};
    int c_cg [2] = '{1, 2};
    int c_oc [2] = '{1, 3};

    conv_win_addr_gen #(
        .IN_W(32), .IN_H(32), .K(5), .CH_GRP(1), .OUT_CH(1), .ADDR_W(16)
    ) u_dut_a (
        .clk(clk), .rst_n(rst_n[0]), .start(start[0]), .in_ready(rdy[0]),
        .in_valid(valid[0]), .in_addr(addr[0]), .wgt_addr(wgt[0]), .oc_idx(oc[0]),
        .first_tap(ft[0]), .last_tap(lt[0]), .last_pix(lp[0]), .busy(busy[0]),
        .done(done[0])
    );

    conv_win_addr_gen #(
        .IN_W(6), .IN_H(6), .K(3), .CH_GRP(2), .OUT_CH(3), .ADDR_W(16)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n[1]), .start(start[1]), .in_ready(rdy[1]),
        .in_valid(valid[1]), .in_addr(addr[1]), .wgt_addr(wgt[1]), .oc_idx(oc[1]),
        .first_tap(ft[1]), .last_tap(lt[1]), .last_pix(lp[1]), .busy(busy[1]),
        .done(done[1])
    );

    int n_vec = 0;
    int n_err = 0;
    int st [2] = '{0, 0};  // 0 idle, 1 run, 2 done
    int n  [2] = '{0, 0};  // index of the tap currently presented
    int lt_cnt [2], lp_cnt [2], done_cnt [2], last_addr [2];

    function automatic void chk(string nm, int i, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d tap=%0d got=%0d want=%0d", nm, i, n[i], act, exp);
        end
    endfunction

    function automatic int ow(int i); return c_iw[i] - c_k[i] + 1; endfunction
    function automatic int oh(int i); return c_ih[i] - c_k[i] + 1; endfunction
    function automatic int tpn(int i); return c_cg[i] * c_k[i] * c_k[i]; endfunction
    function automatic int total(int i); return tpn(i) * ow(i) * oh(i) * c_oc[i]; endfunction

    function automatic void model(input int i, input int nn, output int ea, output int ew,
                                  output int eo, output int ef, output int el, output int ep);
        int t, neu, g, ky, kx, ox, oy, kk;
        kk  = c_k[i] * c_k[i];
        neu = nn / tpn(i);
        t   = nn % tpn(i);
        g   = t / kk;
        ky  = (t % kk) / c_k[i];
        kx  = t % c_k[i];
        ox  = neu % ow(i);
        oy  = (neu / ow(i)) % oh(i);
        eo  = neu / (ow(i) * oh(i));
        ea  = g * c_ih[i] * c_iw[i] + (oy + ky) * c_iw[i] + ox + kx;
        ew  = eo * tpn(i) + t;
        ef  = (t == 0) ? 1 : 0;
        el  = (t == tpn(i) - 1) ? 1 : 0;
        ep  = (el == 1 && (neu % (ow(i) * oh(i))) == ow(i) * oh(i) - 1) ? 1 : 0;
    endfunction

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int ea, ew, eo, ef, el, ep, run;
            run = (st[i] == 1) ? 1 : 0;
            if (run == 1) model(i, n[i], ea, ew, eo, ef, el, ep);
            else begin ea = 0; ew = 0; eo = 0; ef = 0; el = 0; ep = 0; end
            chk("in_valid", i, valid[i], run);
            chk("busy", i, busy[i], run);
            chk("done", i, done[i], (st[i] == 2) ? 1 : 0);
            chk("in_addr", i, addr[i], ea);
            chk("wgt_addr", i, wgt[i], ew);
            chk("oc_idx", i, oc[i], eo);
            chk("first_tap", i, ft[i], ef);
            chk("last_tap", i, lt[i], el);
            chk("last_pix", i, lp[i], ep);
            // Hand-computed pins that anchor the model itself.
            if (run == 1 && i == 0) begin
                case (n[i])
                    0: chk("pin_a0", i, addr[i], 0);
                    1: chk("pin_a1", i, addr[i], 1);
                    2: chk("pin_a2", i, addr[i], 2);
                    3: chk("pin_a3", i, addr[i], 3);
                    4: chk("pin_a4", i, addr[i], 4);
                    5: chk("pin_a5", i, addr[i], 32);
                    24: begin chk("pin_a24", i, addr[i], 132); chk("pin_lt24", i, lt[i], 1); end
                    25: begin chk("pin_a25", i, addr[i], 1); chk("pin_ft25", i, ft[i], 1); end
                    default: ;
                endcase
            end
            if (run == 1 && i == 1) begin
                if (n[i] == 9) chk("pin_g1_addr", i, addr[i], 36);
                if (n[i] == 17) chk("pin_lt17", i, lt[i], 1);
                if (n[i] == 288) chk("pin_oc1_wgt", i, wgt[i], 18);
            end
            if (valid[i] === 1'b1 && rdy[i] === 1'b1) begin
                if (lt[i] === 1'b1) lt_cnt[i]++;
                if (lp[i] === 1'b1) lp_cnt[i]++;
                last_addr[i] = int'(addr[i]);
            end
            if (done[i] === 1'b1) done_cnt[i]++;
            if (rst_n[i] !== 1'b1) begin
                st[i] = 0;
                n[i]  = 0;
            end else begin
                case (st[i])
                    0: if (start[i] === 1'b1) begin st[i] = 1; n[i] = 0; end
                    1: if (rdy[i] === 1'b1) begin
                        if (n[i] == total(i) - 1) st[i] = 2;
                        else n[i]++;
                    end
                    default: st[i] = 0;
                endcase
            end
        end
    end

    task automatic pulse_start(input int i);
        @(posedge clk); #1;
        start[i] = 1'b1;
        @(posedge clk); #1;
        start[i] = 1'b0;
    endtask

    task automatic run_sweep(input int i, input int stall_pct, input int start_pct,
                             input int budget, input int exp_last);
        int seen;
        seen = 0;
        lt_cnt[i] = 0; lp_cnt[i] = 0; done_cnt[i] = 0; last_addr[i] = -1;
        pulse_start(i);
        for (int c = 0; c < budget; c++) begin
            rdy[i]   = ($urandom_range(0, 99) >= stall_pct) ? 1'b1 : 1'b0;
            start[i] = ($urandom_range(0, 99) < start_pct) ? 1'b1 : 1'b0;
            @(posedge clk); #1;
            if (done[i] === 1'b1) begin seen = 1; break; end
        end
        start[i] = 1'b0;
        rdy[i]   = 1'b0;
        chk("sweep_done_seen", i, seen, 1);
        repeat (2) @(negedge clk);
        #1;
        chk("last_tap_count", i, lt_cnt[i], ow(i) * oh(i) * c_oc[i]);
        chk("last_pix_count", i, lp_cnt[i], c_oc[i]);
        chk("last_in_addr", i, last_addr[i], exp_last);
        chk("done_pulses", i, done_cnt[i], 1);
    endtask

    task automatic reset_mid_sweep(input int i, input int at_tap);
        int hit;
        hit = 0;
        pulse_start(i);
        for (int c = 0; c < 4 * at_tap; c++) begin
            if (st[i] == 1 && n[i] == at_tap) begin hit = 1; break; end
            rdy[i] = ($urandom_range(0, 99) >= 30) ? 1'b1 : 1'b0;
            @(posedge clk); #1;
        end
        chk("reached_reset_tap", i, hit, 1);
        rst_n[i] = 1'b0;
        @(posedge clk); #1;
        rst_n[i] = 1'b1;
        rdy[i]   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        pulse_start(i);
        repeat (40) @(posedge clk);
        #1;
        rdy[i] = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            rst_n[i] = 1'b0; start[i] = 1'b0; rdy[i] = 1'b0;
            lt_cnt[i] = 0; lp_cnt[i] = 0; done_cnt[i] = 0; last_addr[i] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        repeat (2) @(posedge clk);
        fork
            begin
                run_sweep(0, 0, 3, 19700, 1023);
                reset_mid_sweep(0, 1000);
            end
            begin
                run_sweep(1, 0, 0, 1000, 71);
                run_sweep(1, 40, 5, 4000, 71);
                run_sweep(1, 15, 10, 2000, 71);
            end
        join
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
